// File: rtl/byte_unstriping_rx_param.sv
// byte_unstriping_rx_param
// Receive-side un-striper. Each physical lane feeds its own small FIFO so that
// skewed lanes can be realigned. A round-robin pointer visits the active lanes
// in order and only advances once the selected lane has produced a symbol,
// which preserves strict byte order. The merged stream leaves through a
// registered valid/ready stage. The active lane count is sampled only while
// the block is idle, so a stream is never split across two lane layouts.
// Lane overflow is reported per lane and is sticky until reset.

module byte_unstriping_rx_param #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 4,
  // Derived width of lane_count / out_lane; leave at its default.
  parameter int CNT_W  = $clog2(LANES) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CNT_W-1:0]          lane_count,
  input  logic [LANES-1:0]          lane_valid,
  input  logic [LANES*DATA_W-1:0]   lane_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [CNT_W-1:0]          out_lane,
  output logic [LANES-1:0]          lane_ovf,
  output logic                      busy
);

  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0]      FILL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ALL   = CNT_W'(LANES);

  // Per-lane FIFO storage and bookkeeping.
  logic [DATA_W-1:0] mem    [LANES][DEPTH];
  logic [AW-1:0]     wr_ptr [LANES];
  logic [AW-1:0]     rd_ptr [LANES];
  logic [AW:0]       fill   [LANES];

  logic [LANES-1:0]  fifo_nonempty;
  logic [LANES-1:0]  fifo_full;
  logic [LANES-1:0]  lane_en;
  logic [LANES-1:0]  push;
  logic [LANES-1:0]  push_ok;
  logic [LANES-1:0]  pop;
  logic [LANES-1:0]  ovf_set;

  // Round-robin selection and configuration.
  logic [CNT_W-1:0]  act_cnt;
  logic [CNT_W-1:0]  cnt_eff;
  logic [CNT_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  rr_next;
  logic [SEL_W-1:0]  sel;
  logic              load;
  logic [DATA_W-1:0] head;

  // Out-of-range lane counts (0 or more than LANES) fall back to all lanes.
  assign cnt_eff = (lane_count == '0 || lane_count > CNT_ALL) ? CNT_ALL : lane_count;

  assign sel     = rr_ptr[SEL_W-1:0];
  assign rr_next = (rr_ptr == act_cnt - CNT_ONE) ? '0 : rr_ptr + CNT_ONE;

  // FIFO status flags and lane enables derived from the current configuration.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    fifo_nonempty = '0;
    fifo_full     = '0;
    lane_en       = '0;
    for (int i = 0; i < LANES; i++) begin
      fifo_nonempty[i] = (fill[i] != '0);
      fifo_full[i]     = (fill[i] == FILL_FULL);
      lane_en[i]       = (CNT_W'(i) < act_cnt);
    end
  end

  // The output register takes a symbol only from the selected lane; an empty
  // selected lane stalls the merge even when other lanes hold data.
  assign load = fifo_nonempty[sel] && (!out_valid || out_ready);
  assign head = mem[sel][rd_ptr[sel]];
  assign busy = (|fifo_nonempty) | out_valid;

  // Push/pop qualification; a full FIFO still accepts a push when it pops.
  always_comb begin
    push    = '0;
    push_ok = '0;
    pop     = '0;
    ovf_set = '0;
    for (int i = 0; i < LANES; i++) begin
      pop[i]     = load && (sel == SEL_W'(i));
      push[i]    = lane_valid[i] && lane_en[i];
      push_ok[i] = push[i] && (!fifo_full[i] || pop[i]);
      ovf_set[i] = push[i] && fifo_full[i] && !pop[i];
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately left out of reset; the fill counters
    // define which entries are meaningful, and resetting a memory array would
    // only cost flops and routing.
    for (int i = 0; i < LANES; i++) begin
      if (push_ok[i]) begin
        mem[i][wr_ptr[i]] <= lane_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers, fill levels and sticky overflow flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        fill[i]   <= '0;
      end
      lane_ovf <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push_ok[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        end
        case ({push_ok[i], pop[i]})
          2'b10:   fill[i] <= fill[i] + FILL_ONE;
          2'b01:   fill[i] <= fill[i] - FILL_ONE;
          default: fill[i] <= fill[i];
        endcase
      end
      lane_ovf <= lane_ovf | ovf_set;
    end
  end

  // Output stage, round-robin pointer and idle-time configuration reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      rr_ptr    <= '0;
      act_cnt   <= CNT_ALL;
    end else begin
      if (load) begin
        out_data  <= head;
        out_lane  <= rr_ptr;
        out_valid <= 1'b1;
        rr_ptr    <= rr_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // While idle nothing can load, so the pointer may be pulled back into
      // range if the new lane count no longer covers it.
      if (!busy) begin
        act_cnt <= cnt_eff;
        if (rr_ptr >= cnt_eff) begin
          rr_ptr <= '0;
        end
      end
    end
  end

endmodule
